regfile_writer: RTL and testbench

REGFILE_WRITER -- requirements
Module: regfile_writer

---
 rtl/regfile_writer.sv | 137 +++++++++++++
 tb/tb_regfile_writer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writer
// Brief    : Arbitrates ALU results and FIFO-buffered load results onto a
//            single registered register-file write port with busy tracking.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_wa,
    input  logic [31:0] alu_wd,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_wa,
    input  logic [31:0] ld_wd,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic [31:0] busy
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_stv_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(DEPTH);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_LIMIT);

    logic [4:0]         r_fifo_wa [DEPTH];
    logic [31:0]        r_fifo_wd [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_stv_w-1:0] r_starve;
    logic               r_we;
    logic [4:0]         r_wa;
    logic [31:0]        r_wd;

    logic               w_empty;
    logic               w_alu_grant;
    logic               w_enq;
    logic               w_deq;
    logic [4:0]         w_head_wa;
    logic [31:0]        w_head_wd;
    logic [31:0]        w_entry_hot [DEPTH];
    logic [31:0]        w_busy_all;

    assign w_empty     = (r_count == '0);
    assign ld_ready    = !rst && (r_count < c_depth);
    // ALU is held off only when it has starved a non-empty FIFO long enough
    assign alu_ready   = !rst && !((r_starve == c_starve_max) && !w_empty);
    assign w_alu_grant = alu_valid && alu_ready;
    assign w_enq       = ld_valid && ld_ready;
    assign w_deq       = !rst && !w_alu_grant && !w_empty;
    assign w_head_wa   = r_fifo_wa[r_rd_ptr];
    assign w_head_wd   = r_fifo_wd[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_wa[r_wr_ptr] <= ld_wa;
            r_fifo_wd[r_wr_ptr] <= ld_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_deq || w_empty) begin
                r_starve <= '0;
            end else if (w_alu_grant && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // Writes to r0 still consume their grant but never assert we
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (w_alu_grant) begin
            r_we <= (alu_wa != 5'd0);
            r_wa <= alu_wa;
            r_wd <= alu_wd;
        end else if (w_deq) begin
            r_we <= (w_head_wa != 5'd0);
            r_wa <= w_head_wa;
            r_wd <= w_head_wd;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign we = r_we;
    assign wa = r_wa;
    assign wd = r_wd;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [c_ptr_w-1:0] w_off;
        logic               w_valid;
        assign w_off   = c_ptr_w'(gi) - r_rd_ptr;
        assign w_valid = ({1'b0, w_off} < r_count);
        assign w_entry_hot[gi] = w_valid ? (32'd1 << r_fifo_wa[gi]) : 32'd0;
    end

    always_comb begin
        w_busy_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_all = w_busy_all | w_entry_hot[i];
        end
    end

    assign busy = {w_busy_all[31:1], 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_regfile_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writer
// Brief    : Self-checking bench for regfile_writer with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writer;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_wa;
    logic [31:0] ld_wd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] busy;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_writer #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_wa     (ld_wa),
        .ld_wd     (ld_wd),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Every write that appears on the port must match the next expected one
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wa=%0d wd=%h, required no write", wa, wd);
            end else begin
                e = exp_q.pop_front();
                if (wa !== e.wa || wd !== e.wd) begin
                    errors++;
                    $display("FAIL write_order: got wa=%0d wd=%h, required wa=%0d wd=%h",
                             wa, wd, e.wa, e.wd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("reset_we", {31'd0, we}, 32'd0);
        chk("reset_wa", {27'd0, wa}, 32'd0);
        chk("reset_wd", wd, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("reset_ld_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("post_reset_ld_ready", {31'd0, ld_ready}, 32'd1);
        tick();
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1;
        alu_wa    = 5'd5;
        alu_wd    = 32'hDEADBEEF;
        exp_q.push_back('{wa: 5'd5, wd: 32'hDEADBEEF});
        @(negedge clk);
        chk("alu_single_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_single_we", {31'd0, we}, 32'd1);
        chk("alu_single_wa", {27'd0, wa}, 32'd5);
        chk("alu_single_wd", wd, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("alu_single_we_after", {31'd0, we}, 32'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1'b1;
            alu_wa    = 5'($urandom_range(31, 1));
            alu_wd    = $urandom;
            exp_q.push_back('{wa: alu_wa, wd: alu_wd});
            @(negedge clk);
            chk("b2b_alu_ready", {31'd0, alu_ready}, 32'd1);
            tick();
        end
        alu_valid = 1'b0;
        tick();
        tick();
    endtask

    // Loads queue behind continuous ALU traffic until the starve limit hits
    task automatic test_loads_starve();
        logic [4:0] regs [4];
        regs[0] = 5'd3; regs[1] = 5'd7; regs[2] = 5'd9; regs[3] = 5'd12;
        for (int c = 0; c < 4; c++) begin
            ld_valid  = 1'b1;
            ld_wa     = regs[c];
            ld_wd     = 32'hB000_0000 + 32'(regs[c]);
            alu_valid = 1'b1;
            alu_wa    = 5'(16 + c);
            alu_wd    = 32'hA000_0000 + 32'(c);
            exp_q.push_back('{wa: alu_wa, wd: alu_wd});
            @(negedge clk);
            chk("starve_ld_ready_fill", {31'd0, ld_ready}, 32'd1);
            chk("starve_alu_ready_fill", {31'd0, alu_ready}, 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        alu_wa   = 5'd20;
        alu_wd   = 32'hA000_0004;
        exp_q.push_back('{wa: 5'd20, wd: 32'hA000_0004});
        @(negedge clk);
        chk("starve_ld_ready_full", {31'd0, ld_ready}, 32'd0);
        chk("starve_busy_full", busy, 32'h0000_1288);
        chk("starve_alu_ready_4th", {31'd0, alu_ready}, 32'd1);
        tick();
        exp_q.push_back('{wa: 5'd3, wd: 32'hB000_0003});
        alu_wa = 5'd21;
        alu_wd = 32'hA000_0005;
        @(negedge clk);
        chk("starve_alu_ready_drop", {31'd0, alu_ready}, 32'd0);
        chk("starve_ld_ready_still_full", {31'd0, ld_ready}, 32'd0);
        tick();
        exp_q.push_back('{wa: 5'd21, wd: 32'hA000_0005});
        @(negedge clk);
        chk("starve_alu_ready_back", {31'd0, alu_ready}, 32'd1);
        chk("starve_ld_ready_back", {31'd0, ld_ready}, 32'd1);
        chk("starve_busy_after_pop", busy, 32'h0000_1280);
        chk("starve_r3_first_wa", {27'd0, wa}, 32'd3);
        tick();
        exp_q.push_back('{wa: 5'd7,  wd: 32'hB000_0007});
        exp_q.push_back('{wa: 5'd9,  wd: 32'hB000_0009});
        exp_q.push_back('{wa: 5'd12, wd: 32'hB000_000C});
        alu_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("starve_busy_drained", busy, 32'd0);
        chk("starve_we_idle", {31'd0, we}, 32'd0);
        tick();
    endtask

    task automatic test_r0();
        alu_valid = 1'b1;
        alu_wa    = 5'd0;
        alu_wd    = 32'h0000_1234;
        @(negedge clk);
        chk("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("r0_alu_we", {31'd0, we}, 32'd0);
        tick();
        ld_valid = 1'b1;
        ld_wa    = 5'd0;
        ld_wd    = 32'h0000_5678;
        @(negedge clk);
        chk("r0_ld_ready", {31'd0, ld_ready}, 32'd1);
        tick();
        ld_wa = 5'd6;
        ld_wd = 32'h0606_0606;
        exp_q.push_back('{wa: 5'd6, wd: 32'h0606_0606});
        @(negedge clk);
        chk("r0_busy_bit0", busy, 32'd0);
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("r0_ld_we", {31'd0, we}, 32'd0);
        chk("r0_busy_r6", busy, 32'h0000_0040);
        tick();
        @(negedge clk);
        chk("r0_then_r6_wa", {27'd0, wa}, 32'd6);
        chk("r0_then_r6_we", {31'd0, we}, 32'd1);
        tick();
    endtask

    task automatic test_full_simul();
        logic [4:0] regs [4];
        regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd10; regs[3] = 5'd11;
        for (int c = 0; c < 4; c++) begin
            ld_valid  = 1'b1;
            ld_wa     = regs[c];
            ld_wd     = 32'hC000_0000 + 32'(regs[c]);
            alu_valid = 1'b1;
            alu_wa    = 5'(20 + c);
            alu_wd    = 32'hD000_0000 + 32'(c);
            exp_q.push_back('{wa: alu_wa, wd: alu_wd});
            tick();
        end
        ld_valid = 1'b0;
        alu_wa   = 5'd24;
        alu_wd   = 32'hD000_0004;
        exp_q.push_back('{wa: 5'd24, wd: 32'hD000_0004});
        @(negedge clk);
        chk("full_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("full_busy", busy, 32'h0000_0C06);
        tick();
        alu_valid = 1'b0;
        ld_valid  = 1'b1;
        ld_wa     = 5'd25;
        ld_wd     = 32'hDEAD_0025;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back('{wa: regs[c], wd: 32'hC000_0000 + 32'(regs[c])});
        end
        @(negedge clk);
        chk("full_deq_ld_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("full_after_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("full_after_busy", busy, 32'h0000_0C04);
        tick();
        repeat (4) tick();
        @(negedge clk);
        chk("full_drained_busy", busy, 32'd0);
        tick();
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c < 3; c++) begin
            ld_valid  = 1'b1;
            ld_wa     = 5'(13 + c);
            ld_wd     = 32'hE000_0000 + 32'(c);
            alu_valid = 1'b1;
            alu_wa    = 5'(26 + c);
            alu_wd    = 32'hF000_0000 + 32'(c);
            exp_q.push_back('{wa: alu_wa, wd: alu_wd});
            tick();
        end
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("rst_mid_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_mid_ld_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_we", {31'd0, we}, 32'd0);
        chk("rst_mid_busy", busy, 32'd0);
        chk("rst_mid_alu_ready_after", {31'd0, alu_ready}, 32'd1);
        chk("rst_mid_ld_ready_after", {31'd0, ld_ready}, 32'd1);
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_mid_no_write", {31'd0, we}, 32'd0);
            tick();
        end
    endtask

    task automatic test_busy();
        ld_valid = 1'b1;
        ld_wa    = 5'd4;
        ld_wd    = 32'h4444_0004;
        @(negedge clk);
        chk("busy_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("busy_before", busy, 32'd0);
        tick();
        ld_valid = 1'b0;
        exp_q.push_back('{wa: 5'd4, wd: 32'h4444_0004});
        @(negedge clk);
        chk("busy_r4_set", busy, 32'h0000_0010);
        chk("busy_we_dequeue_cycle", {31'd0, we}, 32'd0);
        tick();
        @(negedge clk);
        chk("busy_r4_we", {31'd0, we}, 32'd1);
        chk("busy_r4_wa", {27'd0, wa}, 32'd4);
        chk("busy_r4_clear", busy, 32'd0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        alu_valid = 1'b0;
        alu_wa    = '0;
        alu_wd    = '0;
        ld_valid  = 1'b0;
        ld_wa     = '0;
        ld_wd     = '0;
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_loads_starve();
        test_r0();
        test_full_simul();
        test_rst_mid();
        test_busy();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending writes, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
